// File: rtl/uart_msg_sender_if.sv
// Request, configuration and TX-FIFO signals of the UART message sender,
// bundled so the sender and its user see one connection point.
interface uart_msg_sender_if #(
    parameter int NUM_MSG = 8,
    parameter int MAX_LEN = 16
);
    localparam int SEL_W = $clog2(NUM_MSG);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic             req_drop;
    logic             abort;
    logic             cfg_we;
    logic             cfg_len_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [IDX_W-1:0] cfg_idx;
    logic [7:0]       cfg_data;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_err;
    logic             tx_push;
    logic [7:0]       tx_push_data;
    logic             tx_full;
    logic             busy;
    logic             msg_done;
    logic [SEL_W-1:0] msg_done_sel;

    modport slave (
        input  req_valid, req_sel, abort, cfg_we, cfg_len_we, cfg_sel,
               cfg_idx, cfg_data, cfg_len, tx_full,
        output req_ready, req_drop, cfg_err, tx_push, tx_push_data, busy,
               msg_done, msg_done_sel
    );

    modport master (
        output req_valid, req_sel, abort, cfg_we, cfg_len_we, cfg_sel,
               cfg_idx, cfg_data, cfg_len, tx_full,
        input  req_ready, req_drop, cfg_err, tx_push, tx_push_data, busy,
               msg_done, msg_done_sel
    );
endinterface

// File: rtl/uart_msg_sender.sv
// UART command-string sender: queues message-select requests and streams
// the selected entry of a rewritable message table into the TX FIFO,
// optionally followed by a newline.
module uart_msg_sender #(
    parameter int NUM_MSG   = 8,
    parameter int MAX_LEN   = 16,
    parameter int REQ_DEPTH = 4,
    parameter int APPEND_NL = 1
) (
    input logic              clk,
    input logic              reset,
    uart_msg_sender_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_MSG);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, TERM, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       tbl_q [NUM_MSG][MAX_LEN];
    logic [LEN_W-1:0] len_q [NUM_MSG];
    logic [SEL_W-1:0] fifo_q [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [SEL_W-1:0] sel_q, done_sel_q;
    logic [LEN_W-1:0] mlen_q, cnt_q;
    logic             fifo_full, fifo_empty, req_ready, push, pop;
    logic             conflict, cfg_req, cfg_ok;
    logic [LEN_W-1:0] cfg_len_sat;
    logic             tx_push;
    logic [7:0]       tx_data;
    logic             done;

    // Power-up contents of the built-in command strings, first character at index 0.
    function automatic logic [7:0] defByte(input int s, input int i);
        logic [55:0] str;
        int          n;
        str = '0;
        n   = 0;
        case (s)
            0:       begin str = {8'h00, "qstick"};  n = 6; end
            1:       begin str = {8'h00, "golden"};  n = 6; end
            2:       begin str = "sodapop";          n = 7; end
            3:       begin str = {16'h0000, "pause"}; n = 5; end
            4:       begin str = "restart";          n = 7; end
            5:       begin str = {16'h0000, "reset"}; n = 5; end
            default: begin str = '0;                 n = 0; end
        endcase
        if (i < n) defByte = 8'(str >> (8 * (n - 1 - i)));
        else       defByte = 8'h00;
    endfunction

    function automatic logic [LEN_W-1:0] defLen(input int s);
        case (s)
            0, 1:    defLen = LEN_W'(6);
            2, 4:    defLen = LEN_W'(7);
            3, 5:    defLen = LEN_W'(5);
            default: defLen = '0;
        endcase
    endfunction

    // Queue handshake and the guard that keeps queued or in-flight slots from being rewritten.
    always_comb begin
        fifo_full   = (count_q == CNT_W'(REQ_DEPTH));
        fifo_empty  = (count_q == '0);
        req_ready   = !fifo_full && !bus.abort && !reset;
        push        = bus.req_valid && req_ready;
        pop         = (state_q == IDLE) && !fifo_empty && !bus.abort;
        conflict    = (state_q != IDLE) && (bus.cfg_sel == sel_q);
        for (int k = 0; k < REQ_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (fifo_q[rd_ptr_q + PTR_W'(k)] == bus.cfg_sel))
                conflict = 1'b1;
        end
        cfg_req     = bus.cfg_we || bus.cfg_len_we;
        cfg_ok      = cfg_req && !conflict;
        cfg_len_sat = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    end

    // Request FIFO; abort empties it, and a full FIFO refuses even while it pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < REQ_DEPTH; k++) fifo_q[k] <= '0;
        end else if (bus.abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.req_sel;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Message table and lengths; reset restores the built-in commands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_MSG; s++) begin
                len_q[s] <= defLen(s);
                for (int i = 0; i < MAX_LEN; i++) tbl_q[s][i] <= defByte(s, i);
            end
        end else if (cfg_ok && (int'(bus.cfg_sel) < NUM_MSG)) begin
            if (bus.cfg_we && (int'(bus.cfg_idx) < MAX_LEN))
                tbl_q[bus.cfg_sel][bus.cfg_idx] <= bus.cfg_data;
            if (bus.cfg_len_we)
                len_q[bus.cfg_sel] <= cfg_len_sat;
        end
    end

    // Sequencer registers: current slot, its length, byte position and last finished slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            mlen_q     <= '0;
            cnt_q      <= '0;
            done_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) sel_q <= fifo_q[rd_ptr_q];
            if (state_q == LOAD) begin
                mlen_q <= len_q[sel_q];
                cnt_q  <= '0;
            end
            if ((state_q == SEND) && tx_push) cnt_q <= cnt_q + LEN_W'(1);
            if (done) done_sel_q <= sel_q;
        end
    end

    // Next state and TX strobes; abort overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        tx_push = 1'b0;
        tx_data = 8'h00;
        done    = 1'b0;
        case (state_q)
            IDLE: if (pop) state_d = LOAD;
            LOAD: state_d = (len_q[sel_q] == '0) ? DONE : SEND;
            SEND: begin
                tx_push = !bus.tx_full;
                if (tx_push) begin
                    tx_data = tbl_q[sel_q][cnt_q[IDX_W-1:0]];
                    if (cnt_q == mlen_q - LEN_W'(1))
                        state_d = (APPEND_NL != 0) ? TERM : DONE;
                end
            end
            TERM: begin
                tx_push = !bus.tx_full;
                if (tx_push) begin
                    tx_data = 8'h0A;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d = IDLE;
            tx_push = 1'b0;
            tx_data = 8'h00;
            done    = 1'b0;
        end
    end

    // Drive the interface outputs; the finishing slot shows up in the same cycle as the pulse.
    always_comb begin
        bus.req_ready    = req_ready;
        bus.req_drop     = bus.req_valid && !req_ready && !reset;
        bus.cfg_err      = cfg_req && conflict && !reset;
        bus.tx_push      = tx_push;
        bus.tx_push_data = tx_data;
        bus.busy         = (state_q != IDLE);
        bus.msg_done     = done;
        bus.msg_done_sel = done ? sel_q : done_sel_q;
    end
endmodule

// File: tb/tb_uart_msg_sender.sv
// Bench for uart_msg_sender: directed scenarios followed by random traffic,
// all pushes and completions checked against a byte-stream model of the table.
module tb_uart_msg_sender;
    localparam int NUM_MSG = 8;
    localparam int MAX_LEN = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_msg_sender_if #(.NUM_MSG(NUM_MSG), .MAX_LEN(MAX_LEN)) bus ();

    uart_msg_sender #(
        .NUM_MSG(NUM_MSG), .MAX_LEN(MAX_LEN), .REQ_DEPTH(4), .APPEND_NL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, pushCount = 0, doneCount = 0;
    int expQ[$];
    int pushCycQ[$];
    int doneCycQ[$];
    logic [7:0] mTbl [NUM_MSG][MAX_LEN];
    int mLen [NUM_MSG];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setMsg(input int slot, input string s);
        for (int i = 0; i < MAX_LEN; i++) mTbl[slot][i] = 8'h00;
        mLen[slot] = s.len();
        for (int i = 0; i < s.len(); i++) mTbl[slot][i] = s[i];
    endtask

    // Expected stream: message bytes, newline if non-empty, then a completion token 256+slot.
    task automatic expand(input int sel);
        for (int i = 0; i < mLen[sel]; i++) expQ.push_back(int'(mTbl[sel][i]));
        if (mLen[sel] > 0) expQ.push_back(10);
        expQ.push_back(256 + sel);
    endtask

    task automatic scoreboard();
        if (reset) begin
            expQ.delete();
            return;
        end
        if (bus.tx_push) begin
            pushCycQ.push_back(cyc);
            pushCount++;
            if (expQ.size() == 0 || expQ[0] >= 256) checkOutput("pushExpected", bus.tx_push, 0);
            else begin
                checkOutput("txByte", bus.tx_push_data, expQ[0]);
                void'(expQ.pop_front());
            end
        end else begin
            checkOutput("idleData", bus.tx_push_data, 0);
        end
        if (bus.tx_full) checkOutput("holdFull", bus.tx_push, 0);
        if (bus.msg_done) begin
            doneCycQ.push_back(cyc);
            doneCount++;
            if (expQ.size() == 0 || expQ[0] < 256) checkOutput("doneExpected", bus.msg_done, 0);
            else begin
                checkOutput("doneSel", bus.msg_done_sel, expQ[0] - 256);
                void'(expQ.pop_front());
            end
        end
        if (bus.abort) begin
            checkOutput("abortNoPush", bus.tx_push, 0);
            expQ.delete();
        end else if (bus.req_valid && bus.req_ready) begin
            expand(int'(bus.req_sel));
        end
    endtask

    task automatic sampleNow();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sampleNow();
        advance();
    endtask

    task automatic applyStimulus(input logic v, input int sel, input logic full, input logic ab);
        bus.req_valid = v;
        bus.req_sel   = 3'(sel);
        bus.tx_full   = full;
        bus.abort     = ab;
    endtask

    task automatic setCfg(input logic we, input logic lwe, input int sel, input int idx,
                          input logic [7:0] data, input int len);
        bus.cfg_we     = we;
        bus.cfg_len_we = lwe;
        bus.cfg_sel    = 3'(sel);
        bus.cfg_idx    = 4'(idx);
        bus.cfg_data   = data;
        bus.cfg_len    = 5'(len);
    endtask

    task automatic drain(input int maxCyc);
        int n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            cycle();
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        repeat (2) cycle();
    endtask

    task automatic waitPushes(input int target, input int maxCyc);
        int n = 0;
        while (pushCount < target && n < maxCyc) begin
            cycle();
            n++;
        end
        checkOutput("waitPush", pushCount >= target, 1);
    endtask

    // Safety net in case the design stalls the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        int t, base, d0, p0;
        for (int s = 0; s < NUM_MSG; s++) setMsg(s, "");
        setMsg(0, "qstick"); setMsg(1, "golden"); setMsg(2, "sodapop");
        setMsg(3, "pause");  setMsg(4, "restart"); setMsg(5, "reset");
        applyStimulus(0, 0, 0, 0);
        setCfg(0, 0, 0, 0, 8'h00, 0);
        reset = 1'b1;

        // reset state
        repeat (2) cycle();
        sampleNow();
        checkOutput("rstReady", bus.req_ready, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.msg_done, 0);
        advance();
        reset = 1'b0;
        sampleNow();
        checkOutput("postRstReady", bus.req_ready, 1);
        checkOutput("postRstBusy", bus.busy, 0);
        advance();

        // reset in the middle of a message
        applyStimulus(1, 0, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        waitPushes(pushCount + 2, 20);
        reset = 1'b1;
        sampleNow();
        checkOutput("midRstPush", bus.tx_push, 0);
        checkOutput("midRstData", bus.tx_push_data, 0);
        checkOutput("midRstBusy", bus.busy, 0);
        checkOutput("midRstDone", bus.msg_done, 0);
        checkOutput("midRstDoneSel", bus.msg_done_sel, 0);
        checkOutput("midRstCfgErr", bus.cfg_err, 0);
        advance();
        reset = 1'b0;
        base = pushCount;
        repeat (4) cycle();
        checkOutput("fifoEmptyAfterRst", pushCount - base, 0);

        // first message latency and back-to-back bytes
        pushCycQ.delete(); doneCycQ.delete();
        t = cyc;
        applyStimulus(1, 0, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        drain(40);
        checkOutput("qstickPushes", pushCycQ.size(), 7);
        checkOutput("qstickDones", doneCycQ.size(), 1);
        if (pushCycQ.size() == 7 && doneCycQ.size() == 1) begin
            checkOutput("firstPushCyc", pushCycQ[0], t + 3);
            checkOutput("lastPushCyc", pushCycQ[6], t + 9);
            checkOutput("doneCyc", doneCycQ[0], t + 10);
        end

        // backpressure toggling every cycle
        base = pushCount;
        applyStimulus(1, 2, 0, 0); cycle();
        for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
            applyStimulus(0, 0, (k % 2) == 0, 0);
            cycle();
        end
        applyStimulus(0, 0, 0, 0);
        drain(10);
        checkOutput("sodapopPushes", pushCount - base, 8);

        // queueing and overflow
        pushCycQ.delete(); doneCycQ.delete();
        d0 = doneCount;
        applyStimulus(1, 3, 1, 0); cycle();
        applyStimulus(1, 4, 1, 0); cycle();
        applyStimulus(1, 5, 1, 0); cycle();
        applyStimulus(1, 1, 1, 0); cycle();
        applyStimulus(1, 0, 1, 0);
        sampleNow();
        checkOutput("lastSlotReady", bus.req_ready, 1);
        advance();
        applyStimulus(1, 2, 1, 0);
        sampleNow();
        checkOutput("fullReady", bus.req_ready, 0);
        checkOutput("fullDrop", bus.req_drop, 1);
        advance();
        applyStimulus(0, 0, 0, 0);
        drain(120);
        checkOutput("queueDones", doneCount - d0, 5);
        checkOutput("queuePushes", pushCycQ.size(), 34);
        if (pushCycQ.size() == 34 && doneCycQ.size() == 5) begin
            checkOutput("nextMsgGap", pushCycQ[6], pushCycQ[5] + 4);
            checkOutput("doneAfterLast", doneCycQ[0], pushCycQ[5] + 1);
        end

        // abort after three bytes with two requests queued
        base = pushCount;
        applyStimulus(1, 4, 0, 0); cycle();
        applyStimulus(1, 1, 0, 0); cycle();
        applyStimulus(1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 0);
        waitPushes(base + 3, 20);
        applyStimulus(1, 3, 0, 1);
        sampleNow();
        checkOutput("abortPush", bus.tx_push, 0);
        checkOutput("abortReady", bus.req_ready, 0);
        checkOutput("abortDrop", bus.req_drop, 1);
        checkOutput("abortDone", bus.msg_done, 0);
        advance();
        applyStimulus(0, 0, 0, 0);
        sampleNow(); checkOutput("abortBusy1", bus.busy, 0); advance();
        sampleNow(); checkOutput("abortBusy2", bus.busy, 0); advance();
        base = pushCount; d0 = doneCount;
        repeat (10) cycle();
        checkOutput("abortNoMorePush", pushCount - base, 0);
        checkOutput("abortNoDone", doneCount - d0, 0);

        // runtime table rewrite of slot 6
        setCfg(1, 0, 6, 0, 8'h68, 0);
        sampleNow(); checkOutput("cfgHiErr0", bus.cfg_err, 0); advance();
        setCfg(1, 1, 6, 1, 8'h69, 2);
        sampleNow(); checkOutput("cfgHiErr1", bus.cfg_err, 0); advance();
        setCfg(0, 0, 0, 0, 8'h00, 0);
        setMsg(6, "hi");
        base = pushCount;
        applyStimulus(1, 6, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        drain(30);
        checkOutput("hiPushes", pushCount - base, 3);
        setCfg(0, 1, 6, 0, 8'h00, 0);
        sampleNow(); checkOutput("cfgLen0Err", bus.cfg_err, 0); advance();
        setCfg(0, 0, 0, 0, 8'h00, 0);
        mLen[6] = 0;
        base = pushCount; d0 = doneCount;
        applyStimulus(1, 6, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        drain(30);
        checkOutput("emptyPushes", pushCount - base, 0);
        checkOutput("emptyDones", doneCount - d0, 1);

        // write to the slot being sent is refused, other slots accepted
        base = pushCount;
        applyStimulus(1, 1, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        waitPushes(base + 1, 20);
        setCfg(1, 0, 1, 0, 8'h58, 0);
        sampleNow(); checkOutput("busySlotErr", bus.cfg_err, 1); advance();
        setCfg(1, 0, 7, 0, 8'h41, 0);
        sampleNow(); checkOutput("otherSlotErr", bus.cfg_err, 0); advance();
        setCfg(0, 0, 0, 0, 8'h00, 0);
        mTbl[7][0] = 8'h41;
        drain(30);

        // queued slot protected, length saturation
        applyStimulus(1, 2, 1, 0); cycle();
        applyStimulus(1, 3, 1, 0); cycle();
        applyStimulus(0, 0, 1, 0);
        setCfg(0, 1, 3, 0, 8'h00, 1);
        sampleNow(); checkOutput("queuedSlotErr", bus.cfg_err, 1); advance();
        setCfg(1, 0, 2, 0, 8'h58, 0);
        sampleNow(); checkOutput("loadedSlotErr", bus.cfg_err, 1); advance();
        setCfg(0, 1, 7, 0, 8'h00, 20);
        sampleNow(); checkOutput("satLenErr", bus.cfg_err, 0); advance();
        setCfg(0, 0, 0, 0, 8'h00, 0);
        mLen[7] = (20 > MAX_LEN) ? MAX_LEN : 20;
        applyStimulus(0, 0, 0, 0);
        drain(60);
        base = pushCount;
        applyStimulus(1, 7, 0, 0); cycle(); applyStimulus(0, 0, 0, 0);
        drain(60);
        checkOutput("satPushes", pushCount - base, MAX_LEN + 1);

        // random requests, backpressure and occasional abort
        p0 = pushCount;
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
            cycle();
        end
        applyStimulus(0, 0, 0, 0);
        drain(800);
        checkOutput("randomActivity", pushCount > p0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
